// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// One transaction in flight at a time: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 100,
    parameter int RD_LAT = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [2:0]      LAT_M1  = 3'(RD_LAT - 1);

    logic [1:0]        r_state;
    logic              r_prio;
    logic              r_owner;
    logic              r_we;
    logic              r_err;
    logic [2:0]        r_cnt;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [1:0]        r_err_o;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_any;
    logic              w_pick;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_legal;
    logic [1:0]        w_own_oh;

    // With both requesting, the priority pointer decides; otherwise the lone requester wins.
    assign w_any    = m0_req | m1_req;
    assign w_pick   = (m0_req & m1_req) ? r_prio : m1_req;
    assign w_we     = w_pick ? m1_we    : m0_we;
    assign w_addr   = w_pick ? m1_addr  : m0_addr;
    assign w_wdata  = w_pick ? m1_wdata : m0_wdata;
    assign w_legal  = {1'b0, w_addr} < DEPTH_X;
    assign w_own_oh = r_owner ? 2'b10 : 2'b01;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_err_o     <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // Every output is a single-cycle pulse; default them low each cycle.
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_err_o     <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick;
                        r_we    <= w_we;
                        r_err   <= ~w_legal;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_prio  <= ~w_pick;
                        if (w_legal) begin
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= w_we;
                            r_mem_addr  <= w_addr;
                            r_mem_wdata <= w_wdata;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!r_we && !r_err) begin
                        r_cnt   <= LAT_M1;
                        r_state <= S_WAIT;
                    end else begin
                        r_rvalid <= w_own_oh;
                        r_err_o  <= r_err ? w_own_oh : 2'b00;
                        r_state  <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rvalid <= w_own_oh;
                        if (r_owner) r_rdata1 <= mem_rdata;
                        else         r_rdata0 <= mem_rdata;
                        r_state  <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign m0_gnt    = r_gnt[0];
    assign m1_gnt    = r_gnt[1];
    assign m0_rvalid = r_rvalid[0];
    assign m1_rvalid = r_rvalid[1];
    assign m0_err    = r_err_o[0];
    assign m1_err    = r_err_o[1];
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level schedule model checked every cycle,
// directed scenarios with literal expectations, and a second RD_LAT=3 instance.
module tb_dmem_arbiter;

    localparam int RD_LAT = 1;
    localparam int NC     = 4096;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [6:0]  m0_addr = '0, m1_addr = '0;
    logic [63:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [63:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    always #5 clk_in = ~clk_in;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(64), .DEPTH(100), .RD_LAT(RD_LAT)) u_dut (
        .clk_in(clk_in), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Second instance with a 3-cycle memory, exercised only by its port 0.
    logic        t_req = 1'b0, t_we = 1'b0, z_req = 1'b0, z_we = 1'b0;
    logic [6:0]  t_addr = '0, z_addr = '0;
    logic [63:0] t_wd = '0, z_wd = '0;
    logic        t_gnt, t_rv, t_err, t1_gnt, t1_rv, t1_err, t_en, t_mwe;
    logic [63:0] t_rd, t1_rd, t_mwd, t_mrd;
    logic [6:0]  t_maddr;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(64), .DEPTH(100), .RD_LAT(3)) u_dut3 (
        .clk_in(clk_in), .reset(reset),
        .m0_req(t_req), .m0_we(t_we), .m0_addr(t_addr), .m0_wdata(t_wd),
        .m0_gnt(t_gnt), .m0_rvalid(t_rv), .m0_rdata(t_rd), .m0_err(t_err),
        .m1_req(z_req), .m1_we(z_we), .m1_addr(z_addr), .m1_wdata(z_wd),
        .m1_gnt(t1_gnt), .m1_rvalid(t1_rv), .m1_rdata(t1_rd), .m1_err(t1_err),
        .mem_en(t_en), .mem_we(t_mwe), .mem_addr(t_maddr), .mem_wdata(t_mwd),
        .mem_rdata(t_mrd)
    );

    int n_vec = 0, n_err = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [63:0] init_word(input int i);
        return {32'h5EED0000 + 32'(i), 32'hFACE0000 + 32'(i)};
    endfunction

    // ---------------- memory environment ----------------
    logic [63:0] mem [128];
    logic [63:0] rpipe [RD_LAT];
    logic [63:0] rpipe3 [3];
    assign mem_rdata = rpipe[RD_LAT-1];
    assign t_mrd     = rpipe3[2];

    always @(posedge clk_in) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : {32'hBAD0BAD0, cyc};
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        rpipe3[0] <= (t_en && !t_mwe) ? 64'h0123456789ABCDEF : {32'hBAD3BAD3, cyc};
        rpipe3[1] <= rpipe3[0];
        rpipe3[2] <= rpipe3[1];
    end

    // ---------------- schedule model ----------------
    logic [1:0]        e_gnt [NC];
    logic [1:0]        e_rv  [NC];
    logic [1:0]        e_err [NC];
    logic [1:0][63:0]  e_rd  [NC];
    logic              e_en  [NC];
    logic              e_we  [NC];
    logic [6:0]        e_ad  [NC];
    logic [63:0]       e_wd  [NC];
    logic [63:0]       ref_mem [128];
    bit armed = 0;
    int ptr = 0, nxt = 1 << 30;

    task automatic clr(input int i);
        e_gnt[i] = '0; e_rv[i] = '0; e_err[i] = '0; e_rd[i] = '0;
        e_en[i] = 1'b0; e_we[i] = 1'b0; e_ad[i] = '0; e_wd[i] = '0;
    endtask

    initial begin
        for (int i = 0; i < NC; i++) clr(i);
        for (int i = 0; i < 128; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem[5]     = 64'h00000000DEADBEEF;
        ref_mem[5] = 64'h00000000DEADBEEF;
        for (int i = 0; i < RD_LAT; i++) rpipe[i] = '0;
        for (int i = 0; i < 3; i++) rpipe3[i] = '0;
    end

    // Index k holds what the DUT must show in the cycle after clock edge k.
    always @(posedge clk_in) begin
        int p, r;
        logic w, lg;
        logic [6:0] a;
        logic [63:0] d;
        cyc = cyc + 1;
        if (!reset) begin
            armed = 1;
            ptr   = 0;
            nxt   = cyc + 1;
            for (int i = cyc; i < cyc + 9; i++) clr(i);
        end else if (armed && cyc >= nxt && (m0_req || m1_req)) begin
            p   = (m0_req && m1_req) ? ptr : (m1_req ? 1 : 0);
            ptr = 1 - p;
            w   = p ? m1_we : m0_we;
            a   = p ? m1_addr : m0_addr;
            d   = p ? m1_wdata : m0_wdata;
            lg  = (int'(a) < 100);
            e_gnt[cyc][p] = 1'b1;
            if (lg) begin
                e_en[cyc] = 1'b1; e_we[cyc] = w; e_ad[cyc] = a; e_wd[cyc] = d;
            end
            r = (lg && !w) ? cyc + 1 + RD_LAT : cyc + 1;
            e_rv[r][p]  = 1'b1;
            e_err[r][p] = ~lg;
            e_rd[r][p]  = (lg && !w) ? ref_mem[a] : 64'h0;
            if (lg && w) ref_mem[a] = d;
            nxt = r + 2;
        end
    end

    always @(negedge clk_in) begin
        if (armed) begin
            chk("m0_gnt", {63'b0, m0_gnt}, {63'b0, e_gnt[cyc][0]});
            chk("m1_gnt", {63'b0, m1_gnt}, {63'b0, e_gnt[cyc][1]});
            chk("m0_rvalid", {63'b0, m0_rvalid}, {63'b0, e_rv[cyc][0]});
            chk("m1_rvalid", {63'b0, m1_rvalid}, {63'b0, e_rv[cyc][1]});
            chk("mem_en", {63'b0, mem_en}, {63'b0, e_en[cyc]});
            if (e_rv[cyc][0]) begin
                chk("m0_rdata", m0_rdata, e_rd[cyc][0]);
                chk("m0_err", {63'b0, m0_err}, {63'b0, e_err[cyc][0]});
            end
            if (e_rv[cyc][1]) begin
                chk("m1_rdata", m1_rdata, e_rd[cyc][1]);
                chk("m1_err", {63'b0, m1_err}, {63'b0, e_err[cyc][1]});
            end
            if (e_en[cyc]) begin
                chk("mem_we", {63'b0, mem_we}, {63'b0, e_we[cyc]});
                chk("mem_addr", {57'b0, mem_addr}, {57'b0, e_ad[cyc]});
                chk("mem_wdata", mem_wdata, e_wd[cyc]);
            end
        end
    end

    // Grant order and response times for the contention scenario.
    int gq[$];
    int rq[$];
    always @(negedge clk_in) begin
        if (armed) begin
            if (m0_gnt) gq.push_back(0);
            if (m1_gnt) gq.push_back(1);
            if (m0_rvalid || m1_rvalid) rq.push_back(cyc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xact(input int p, input logic w, input logic [6:0] a, input logic [63:0] d,
                        output int g, output int r, output logic en_g,
                        output logic [63:0] rd, output logic er);
        @(negedge clk_in);
        if (p == 0) begin m0_req = 1; m0_we = w; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = 1; m1_we = w; m1_addr = a; m1_wdata = d; end
        g = -1; r = -1; en_g = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk_in);
            if ((p == 0) ? m0_gnt : m1_gnt) begin g = cyc; en_g = mem_en; end
        end
        m0_req = 0; m1_req = 0;
        if (g < 0) begin tmo("gnt"); return; end
        for (int i = 0; i < 20 && r < 0; i++) begin
            @(negedge clk_in);
            if ((p == 0) ? m0_rvalid : m1_rvalid) begin
                r  = cyc;
                rd = (p == 0) ? m0_rdata : m1_rdata;
                er = (p == 0) ? m0_err : m1_err;
            end
        end
        if (r < 0) tmo("rvalid");
    endtask

    initial begin
        int g, r, c0, c1, first;
        logic en_g, er;
        logic [63:0] rd;

        repeat (3) @(negedge clk_in);
        chk("rst_gnt", {62'b0, m1_gnt, m0_gnt}, 64'h0);
        chk("rst_rvalid", {62'b0, m1_rvalid, m0_rvalid}, 64'h0);
        chk("rst_err", {62'b0, m1_err, m0_err}, 64'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 64'h0);
        chk("rst_mem", {55'b0, mem_addr, mem_en, mem_we}, 64'h0);
        chk("rst_wdata", mem_wdata, 64'h0);
        reset = 1;

        // read of word 5
        xact(0, 1'b0, 7'd5, 64'h0, g, r, en_g, rd, er);
        chk("t1_en", {63'b0, en_g}, 64'h1);
        chk("t1_lat", 64'(r - g), 64'(RD_LAT + 1));
        chk("t1_rdata", rd, 64'h00000000DEADBEEF);
        chk("t1_err", {63'b0, er}, 64'h0);

        // port-1 write then read back
        xact(1, 1'b1, 7'd10, 64'h1122334455667788, g, r, en_g, rd, er);
        chk("t2w_lat", 64'(r - g), 64'h1);
        chk("t2w_rdata", rd, 64'h0);
        xact(1, 1'b0, 7'd10, 64'h0, g, r, en_g, rd, er);
        chk("t2r_rdata", rd, 64'h1122334455667788);

        // out-of-range addresses, then a legal read
        xact(0, 1'b0, 7'd100, 64'h0, g, r, en_g, rd, er);
        chk("t4a_en", {63'b0, en_g}, 64'h0);
        chk("t4a_lat", 64'(r - g), 64'h1);
        chk("t4a_err", {63'b0, er}, 64'h1);
        chk("t4a_rdata", rd, 64'h0);
        xact(0, 1'b0, 7'd127, 64'h0, g, r, en_g, rd, er);
        chk("t4b_err", {63'b0, er}, 64'h1);
        chk("t4b_en", {63'b0, en_g}, 64'h0);
        xact(0, 1'b0, 7'd3, 64'h0, g, r, en_g, rd, er);
        chk("t4c_err", {63'b0, er}, 64'h0);
        chk("t4c_rdata", rd, 64'h5EED0003FACE0003);

        // contention straight out of reset (pointer was left at port 1)
        @(negedge clk_in); reset = 0;
        @(negedge clk_in); reset = 1;
        gq.delete(); rq.delete();
        m0_req = 1; m0_we = 0; m0_addr = 7'd1;
        m1_req = 1; m1_we = 0; m1_addr = 7'd2;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 40 && (m0_req || m1_req); i++) begin
            @(negedge clk_in);
            if (m0_gnt) begin c0++; if (c0 >= 2) m0_req = 0; end
            if (m1_gnt) begin c1++; if (c1 >= 2) m1_req = 0; end
        end
        if (m0_req || m1_req) begin tmo("t3_grants"); m0_req = 0; m1_req = 0; end
        repeat (8) @(negedge clk_in);
        chk("t3_ngnt", 64'(gq.size()), 64'h4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("t3_order", 64'(gq[i]), 64'(i % 2));
        chk("t3_nrv", 64'(rq.size()), 64'h4);
        for (int i = 0; i + 1 < rq.size(); i++) chk("t3_spacing", 64'(rq[i+1] - rq[i]), 64'(RD_LAT + 3));

        // reset in the WAIT cycle of a port-1 read
        m1_req = 1; m1_we = 0; m1_addr = 7'd7;
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk_in);
            if (m1_gnt) g = cyc;
        end
        m1_req = 0;
        if (g < 0) tmo("t5_gnt");
        @(negedge clk_in); reset = 0;
        @(negedge clk_in);
        chk("t5_m1_rvalid", {63'b0, m1_rvalid}, 64'h0);
        chk("t5_outs", {59'b0, m0_gnt, m1_gnt, m0_rvalid, mem_en, mem_we}, 64'h0);
        chk("t5_data", m0_rdata | m1_rdata, 64'h0);
        reset = 1;
        m0_req = 1; m0_addr = 7'd4; m0_we = 0;
        m1_req = 1; m1_addr = 7'd6; m1_we = 0;
        first = -1;
        for (int i = 0; i < 40 && (m0_req || m1_req); i++) begin
            @(negedge clk_in);
            if (first < 0 && (m0_gnt || m1_gnt)) first = m1_gnt ? 1 : 0;
            if (m0_gnt) m0_req = 0;
            if (m1_gnt) m1_req = 0;
        end
        if (m0_req || m1_req) begin tmo("t5_grants"); m0_req = 0; m1_req = 0; end
        chk("t5_first", 64'(first), 64'h0);
        repeat (8) @(negedge clk_in);

        // RD_LAT=3 instance: read of word 0
        t_req = 1; t_we = 0; t_addr = 7'd0;
        g = -1;
        for (int i = 0; i < 20 && g < 0; i++) begin
            @(negedge clk_in);
            if (t_gnt) begin g = cyc; chk("t6_en_issue", {63'b0, t_en}, 64'h1); end
        end
        t_req = 0;
        if (g < 0) tmo("t6_gnt");
        else begin
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk_in);
                chk("t6_en_off", {63'b0, t_en}, 64'h0);
                chk("t6_rvalid", {63'b0, t_rv}, {63'b0, k == 4});
                if (k == 4) begin
                    chk("t6_rdata", t_rd, 64'h0123456789ABCDEF);
                    chk("t6_err", {63'b0, t_err}, 64'h0);
                end
            end
            chk("t6_m1", {61'b0, t1_gnt, t1_rv, t1_err}, 64'h0);
            chk("t6_m1_rdata", t1_rd, 64'h0);
        end
        repeat (3) @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
